// File: rtl/waveform_stream_bank.sv
// Multi-slot waveform store: captures an AXI-stream into one BRAM slot and replays a slot N+1 times without bubbles.
// Define WFSTREAM_CONT_LOOP_EN to enable continuous replay (parameter bit 64) terminated by wf_stop.
module waveform_stream_bank #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int NUM_SLOTS = 4
) (
   input  logic                 clk_in1,
   input  logic                 aresetn,
   input  logic [127:0]         waveform_parameters,
   input  logic                 init_wf_write,
   output logic                 wf_write_ready,
   input  logic                 wf_stop,
   input  logic [DATA_W-1:0]    wfin_axis_tdata,
   input  logic                 wfin_axis_tvalid,
   input  logic                 wfin_axis_tlast,
   output logic                 wfin_axis_tready,
   output logic [DATA_W-1:0]    wfout_axis_tdata,
   output logic                 wfout_axis_tvalid,
   output logic                 wfout_axis_tlast,
   input  logic                 wfout_axis_tready,
   output logic [NUM_SLOTS-1:0] slot_valid,
   output logic                 wr_err
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int MEM_AW = ADDR_W + $clog2(NUM_SLOTS);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [SLOT_W-1:0] SLOT_MASK = SLOT_W'(NUM_SLOTS - 1);
   localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DATA,
      S_WR_DRAIN,
      S_RD_PRIME,
      S_RD_DATA
   } state_t;

   state_t state_q, state_d;
   logic   ready_q;
   logic   wr_err_q, err_d;

   // Parameter word decode
   logic [31:0]       p_len;
   logic [SLOT_W-1:0] p_wr_slot, p_rd_slot;
   logic [15:0]       p_rep;
   logic              p_cont;
   logic              stop_hit;
   logic              len_ok;
   logic              unused_ok;

   assign p_len     = waveform_parameters[31:0];
   assign p_wr_slot = waveform_parameters[32 +: SLOT_W] & SLOT_MASK;
   assign p_rd_slot = waveform_parameters[36 +: SLOT_W] & SLOT_MASK;
   assign p_rep     = waveform_parameters[55:40];
   assign len_ok    = (p_len != 32'd0) && (p_len <= 32'(DEPTH));
   assign unused_ok = ^{waveform_parameters, wf_stop};

   // Capture bookkeeping
   logic [SLOT_W-1:0]    wr_slot_q;
   logic [CNT_W-1:0]     wr_len_q, wr_cnt_q;
   logic [NUM_SLOTS-1:0] slot_valid_q;
   logic [CNT_W-1:0]     slot_len_q [NUM_SLOTS];
   logic                 wr_en, wr_last, start_wr, commit;
   logic [CNT_W-1:0]     commit_len;

   // Replay bookkeeping: the issue side runs ahead of the output skid
   logic [SLOT_W-1:0] rd_slot_q;
   logic [CNT_W-1:0]  rd_len_q, iss_addr_q;
   logic [15:0]       rep_q, iss_pass_q;
   logic              iss_done_q, cont_q;
   logic              start_rd, issue, iss_end, iss_last, final_pass;

   // BRAM and output skid
   logic [DATA_W-1:0] mem [2 ** MEM_AW];
   logic [MEM_AW-1:0] wr_addr, rd_addr;
   logic [DATA_W-1:0] rd_q;
   logic              rd_vld_q, rd_last_q;
   logic [DATA_W-1:0] sk_data_q [2];
   logic [1:0]        sk_last_q;
   logic [1:0]        occ_q;
   logic [2:0]        fill;
   logic              pop;

`ifdef WFSTREAM_CONT_LOOP_EN
   logic stop_q;

   always_ff @(posedge clk_in1) begin
      if (!aresetn)
         stop_q <= 1'b0;
      else if (start_rd)
         stop_q <= 1'b0;
      else if (wf_stop)
         stop_q <= 1'b1;
   end

   assign p_cont   = waveform_parameters[64];
   assign stop_hit = stop_q | wf_stop;
`else
   assign p_cont   = 1'b0;
   assign stop_hit = 1'b0;
`endif

   assign wr_last    = (wr_cnt_q == wr_len_q - ONE);
   assign iss_end    = (iss_addr_q == rd_len_q - ONE);
   assign final_pass = cont_q ? stop_hit : (iss_pass_q == rep_q);
   assign iss_last   = iss_end && final_pass;
   assign pop        = wfout_axis_tvalid && wfout_axis_tready;
   // Words held after this cycle's pop plus the read in flight; at most two may be owed to the skid.
   assign fill       = {1'b0, occ_q} + {2'b00, rd_vld_q} - {2'b00, pop};
   assign wr_addr    = MEM_AW'({wr_slot_q, wr_cnt_q[ADDR_W-1:0]});
   assign rd_addr    = MEM_AW'({rd_slot_q, iss_addr_q[ADDR_W-1:0]});

   // NOTE: every signal driven here gets a default first, so no path through the block can infer a latch.
   always_comb begin
      state_d    = state_q;
      err_d      = 1'b0;
      start_wr   = 1'b0;
      start_rd   = 1'b0;
      commit     = 1'b0;
      commit_len = wr_len_q;
      wr_en      = 1'b0;
      issue      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (ready_q && init_wf_write) begin
               if (len_ok) begin
                  start_wr = 1'b1;
                  state_d  = S_WR_DATA;
               end else begin
                  err_d = 1'b1;
               end
            end else if (ready_q && wfout_axis_tready && slot_valid_q[p_rd_slot]) begin
               start_rd = 1'b1;
               state_d  = S_RD_PRIME;
            end
         end
         S_WR_DATA: begin
            if (wfin_axis_tvalid) begin
               wr_en = 1'b1;
               if (wr_last) begin
                  commit = 1'b1;
                  if (wfin_axis_tlast) begin
                     state_d = S_IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_WR_DRAIN;
                  end
               end else if (wfin_axis_tlast) begin
                  commit     = 1'b1;
                  commit_len = wr_cnt_q + ONE;
                  err_d      = 1'b1;
                  state_d    = S_IDLE;
               end
            end
         end
         S_WR_DRAIN: begin
            if (wfin_axis_tvalid && wfin_axis_tlast)
               state_d = S_IDLE;
         end
         S_RD_PRIME: begin
            issue   = !iss_done_q;
            state_d = S_RD_DATA;
         end
         S_RD_DATA: begin
            issue = !iss_done_q && (fill < 3'd2);
            if (pop && sk_last_q[0])
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in1) begin
      if (!aresetn) begin
         state_q  <= S_IDLE;
         ready_q  <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ready_q  <= (state_d == S_IDLE);
         wr_err_q <= err_d;
      end
   end

   always_ff @(posedge clk_in1) begin
      if (!aresetn) begin
         wr_slot_q    <= '0;
         wr_len_q     <= '0;
         wr_cnt_q     <= '0;
         slot_valid_q <= '0;
         for (int i = 0; i < NUM_SLOTS; i++)
            slot_len_q[i] <= '0;
      end else begin
         if (start_wr) begin
            wr_slot_q               <= p_wr_slot;
            wr_len_q                <= CNT_W'(p_len);
            wr_cnt_q                <= '0;
            slot_valid_q[p_wr_slot] <= 1'b0;
         end else if (wr_en) begin
            wr_cnt_q <= wr_cnt_q + ONE;
         end
         if (commit) begin
            slot_valid_q[wr_slot_q] <= 1'b1;
            slot_len_q[wr_slot_q]   <= commit_len;
         end
      end
   end

   always_ff @(posedge clk_in1) begin
      if (!aresetn) begin
         rd_slot_q  <= '0;
         rd_len_q   <= '0;
         rep_q      <= '0;
         cont_q     <= 1'b0;
         iss_addr_q <= '0;
         iss_pass_q <= '0;
         iss_done_q <= 1'b0;
      end else if (start_rd) begin
         rd_slot_q  <= p_rd_slot;
         rd_len_q   <= slot_len_q[p_rd_slot];
         rep_q      <= p_rep;
         cont_q     <= p_cont;
         iss_addr_q <= '0;
         iss_pass_q <= '0;
         iss_done_q <= 1'b0;
      end else if (issue) begin
         if (iss_end) begin
            iss_addr_q <= '0;
            iss_pass_q <= iss_pass_q + 16'd1;
         end else begin
            iss_addr_q <= iss_addr_q + ONE;
         end
         if (iss_last)
            iss_done_q <= 1'b1;
      end
   end

   // NOTE: the BRAM array has no reset; contents survive reset and only slot_valid/lengths gate their use.
   always_ff @(posedge clk_in1) begin
      if (wr_en)
         mem[wr_addr] <= wfin_axis_tdata;
      if (issue)
         rd_q <= mem[rd_addr];
   end

   always_ff @(posedge clk_in1) begin
      if (!aresetn) begin
         rd_vld_q  <= 1'b0;
         rd_last_q <= 1'b0;
      end else begin
         rd_vld_q  <= issue;
         rd_last_q <= issue && iss_last;
      end
   end

   // Two-entry skid: entry 0 drives the port, entry 1 absorbs the word in flight during a stall.
   always_ff @(posedge clk_in1) begin
      if (!aresetn) begin
         occ_q        <= '0;
         sk_data_q[0] <= '0;
         sk_data_q[1] <= '0;
         sk_last_q    <= '0;
      end else begin
         unique case ({rd_vld_q, pop})
            2'b10: begin
               if (occ_q == 2'd0) begin
                  sk_data_q[0] <= rd_q;
                  sk_last_q[0] <= rd_last_q;
               end else begin
                  sk_data_q[1] <= rd_q;
                  sk_last_q[1] <= rd_last_q;
               end
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               sk_data_q[0] <= sk_data_q[1];
               sk_last_q[0] <= sk_last_q[1];
               occ_q        <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  sk_data_q[0] <= rd_q;
                  sk_last_q[0] <= rd_last_q;
               end else begin
                  sk_data_q[0] <= sk_data_q[1];
                  sk_last_q[0] <= sk_last_q[1];
                  sk_data_q[1] <= rd_q;
                  sk_last_q[1] <= rd_last_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign wf_write_ready    = ready_q;
   assign wfin_axis_tready  = (state_q == S_WR_DATA) || (state_q == S_WR_DRAIN);
   assign wfout_axis_tvalid = (occ_q != 2'd0);
   assign wfout_axis_tdata  = sk_data_q[0];
   assign wfout_axis_tlast  = sk_last_q[0] && wfout_axis_tvalid;
   assign slot_valid        = slot_valid_q;
   assign wr_err            = wr_err_q;

   a_skid_bound : assert property (@(posedge clk_in1) disable iff (!aresetn)
      ({1'b0, occ_q} + {2'b00, rd_vld_q}) <= 3'd2);

   a_stall_hold : assert property (@(posedge clk_in1) disable iff (!aresetn)
      (wfout_axis_tvalid && !wfout_axis_tready) |=>
         (wfout_axis_tvalid && $stable(wfout_axis_tdata) && $stable(wfout_axis_tlast)));

endmodule

// File: tb/tb_waveform_stream_bank.sv
// Directed bench for waveform_stream_bank: capture, replay, backpressure, capture faults and reset abort.
module tb_waveform_stream_bank;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 10;
   localparam int NUM_SLOTS = 4;

   logic                 clk_in1 = 1'b0;
   logic                 aresetn;
   logic [127:0]         params;
   logic                 init_wf_write;
   logic                 wf_write_ready;
   logic                 wf_stop;
   logic [DATA_W-1:0]    in_data;
   logic                 in_valid, in_last, in_ready;
   logic [DATA_W-1:0]    out_data;
   logic                 out_valid, out_last, out_ready;
   logic [NUM_SLOTS-1:0] slot_valid;
   logic                 wr_err;

   int checks = 0;
   int errors = 0;
   logic [15:0] stall_bits = 16'b1011_0010_1101_0110;

   always #5 clk_in1 = ~clk_in1;

   waveform_stream_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SLOTS(NUM_SLOTS)) dut (
      .clk_in1             (clk_in1),
      .aresetn             (aresetn),
      .waveform_parameters (params),
      .init_wf_write       (init_wf_write),
      .wf_write_ready      (wf_write_ready),
      .wf_stop             (wf_stop),
      .wfin_axis_tdata     (in_data),
      .wfin_axis_tvalid    (in_valid),
      .wfin_axis_tlast     (in_last),
      .wfin_axis_tready    (in_ready),
      .wfout_axis_tdata    (out_data),
      .wfout_axis_tvalid   (out_valid),
      .wfout_axis_tlast    (out_last),
      .wfout_axis_tready   (out_ready),
      .slot_valid          (slot_valid),
      .wr_err              (wr_err)
   );

   function automatic logic [31:0] pat(input int s, input int i);
      return {8'hA5, 8'(s), 16'(i)};
   endfunction

   // Inputs change on the falling edge; outputs are sampled there too, away from the active edge.
   task automatic send_write(input int slot, input int len, input int nbeats, input int last_beat,
                             output int err_seen, output int not_ready);
      err_seen  = 0;
      not_ready = 0;
      for (int i = 0; i < 50 && !wf_write_ready; i++)
         @(negedge clk_in1);
      params         = '0;
      params[31:0]   = 32'(len);
      params[35:32]  = 4'(slot);
      init_wf_write  = 1'b1;
      @(negedge clk_in1);
      err_seen      += int'(wr_err);
      init_wf_write  = 1'b0;
      for (int k = 1; k <= nbeats; k++) begin
         in_data  = pat(slot, k - 1);
         in_valid = 1'b1;
         in_last  = (k == last_beat);
         if (!in_ready) not_ready++;
         @(negedge clk_in1);
         err_seen += int'(wr_err);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk_in1);
      err_seen += int'(wr_err);
   endtask

   task automatic run_replay(input int slot, input int len, input int rep, input bit cont,
                             input int stall_mode, input int stop_at,
                             output int nwords, output int last_pos, output int nlast,
                             output int data_err, output int hold_err, output int span,
                             output int timeout);
      int first;
      logic [31:0] prev_d;
      logic prev_l;
      bit prev_stall, done, trail;
      nwords = 0; last_pos = 0; nlast = 0; data_err = 0; hold_err = 0; span = 0; timeout = 0;
      first = -1; prev_d = '0; prev_l = 1'b0; prev_stall = 1'b0; done = 1'b0; trail = 1'b0;
      params         = '0;
      params[39:36]  = 4'(slot);
      params[55:40]  = 16'(rep);
      params[64]     = cont;
      out_ready      = 1'b1;
      @(negedge clk_in1);
      for (int cyc = 0; cyc < 600 && !done; cyc++) begin
         out_ready = (stall_mode == 0) ? 1'b1 : stall_bits[cyc % 16];
         wf_stop   = (stop_at >= 0) && (nwords == stop_at);
         if (prev_stall && (out_data !== prev_d || out_last !== prev_l || out_valid !== 1'b1))
            hold_err++;
         if (out_valid && first < 0) first = cyc;
         if (out_valid && out_ready) begin
            if (out_data !== pat(slot, nwords % len)) data_err++;
            nwords++;
            if (out_last) begin
               nlast++;
               if (last_pos == 0) last_pos = nwords;
               done = 1'b1;
               span = cyc - first + 1;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         prev_l     = out_last;
         @(negedge clk_in1);
      end
      if (!done) timeout = 1;
      out_ready = 1'b0;
      wf_stop   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (out_valid) trail = 1'b1;
         @(negedge clk_in1);
      end
      data_err += int'(trail);
   endtask

   task automatic test_reset;
      aresetn = 1'b0;
      repeat (3) @(negedge clk_in1);
      checks++; if (wf_write_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %b expected 0", wf_write_ready); end
      checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL reset_out: got valid=%b last=%b data=%h expected all 0", out_valid, out_last, out_data); end
      checks++; if (slot_valid !== 4'b0000 || wr_err !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL reset_misc: got slot_valid=%b wr_err=%b in_ready=%b expected 0", slot_valid, wr_err, in_ready); end
      aresetn = 1'b1;
      @(negedge clk_in1);
      checks++; if (wf_write_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", wf_write_ready); end
   endtask

   task automatic test_write_basic;
      int e, nr;
      send_write(1, 8, 8, 8, e, nr);
      checks++; if (e !== 0) begin errors++; $display("FAIL write_basic_err: got %0d pulses expected 0", e); end
      checks++; if (nr !== 0) begin errors++; $display("FAIL write_basic_tready: got %0d stalled beats expected 0", nr); end
      checks++; if (slot_valid !== 4'b0010) begin errors++; $display("FAIL write_basic_slot_valid: got %b expected 0010", slot_valid); end
      checks++; if (wf_write_ready !== 1'b1) begin errors++; $display("FAIL write_basic_ready: got %b expected 1", wf_write_ready); end
   endtask

   task automatic test_replay_single;
      int n, lp, nl, de, he, sp, to;
      run_replay(1, 8, 0, 1'b0, 0, -1, n, lp, nl, de, he, sp, to);
      checks++; if (to !== 0 || n !== 8) begin errors++; $display("FAIL replay_single_count: got %0d words (timeout=%0d) expected 8", n, to); end
      checks++; if (lp !== 8 || nl !== 1) begin errors++; $display("FAIL replay_single_tlast: got first tlast at %0d, %0d tlasts expected 8, 1", lp, nl); end
      checks++; if (de !== 0) begin errors++; $display("FAIL replay_single_data: got %0d bad words expected 0", de); end
   endtask

   task automatic test_back_to_back;
      int n, lp, nl, de, he, sp, to;
      run_replay(1, 8, 2, 1'b0, 0, -1, n, lp, nl, de, he, sp, to);
      checks++; if (to !== 0 || n !== 24) begin errors++; $display("FAIL b2b_count: got %0d words (timeout=%0d) expected 24", n, to); end
      checks++; if (sp !== 24) begin errors++; $display("FAIL b2b_bubbles: got span %0d cycles expected 24", sp); end
      checks++; if (lp !== 24 || nl !== 1) begin errors++; $display("FAIL b2b_tlast: got first tlast at %0d, %0d tlasts expected 24, 1", lp, nl); end
      checks++; if (de !== 0) begin errors++; $display("FAIL b2b_data: got %0d bad words expected 0", de); end
   endtask

   task automatic test_backpressure;
      int n, lp, nl, de, he, sp, to;
      run_replay(1, 8, 1, 1'b0, 1, -1, n, lp, nl, de, he, sp, to);
      checks++; if (to !== 0 || n !== 16) begin errors++; $display("FAIL bp_count: got %0d words (timeout=%0d) expected 16", n, to); end
      checks++; if (de !== 0) begin errors++; $display("FAIL bp_data: got %0d bad words expected 0", de); end
      checks++; if (he !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stall cycles expected 0", he); end
      checks++; if (lp !== 16 || nl !== 1) begin errors++; $display("FAIL bp_tlast: got first tlast at %0d, %0d tlasts expected 16, 1", lp, nl); end
   endtask

   task automatic test_short_tlast;
      int e, nr, n, lp, nl, de, he, sp, to;
      send_write(2, 8, 5, 5, e, nr);
      checks++; if (e !== 1) begin errors++; $display("FAIL short_err: got %0d pulses expected 1", e); end
      checks++; if (slot_valid !== 4'b0110) begin errors++; $display("FAIL short_slot_valid: got %b expected 0110", slot_valid); end
      run_replay(2, 5, 0, 1'b0, 0, -1, n, lp, nl, de, he, sp, to);
      checks++; if (to !== 0 || n !== 5 || lp !== 5) begin errors++; $display("FAIL short_replay: got %0d words, tlast at %0d expected 5, 5", n, lp); end
      checks++; if (de !== 0) begin errors++; $display("FAIL short_data: got %0d bad words expected 0", de); end
   endtask

   task automatic test_missing_tlast;
      int e, nr, n, lp, nl, de, he, sp, to;
      send_write(3, 8, 12, 12, e, nr);
      checks++; if (e !== 1) begin errors++; $display("FAIL drain_err: got %0d pulses expected 1", e); end
      checks++; if (nr !== 0) begin errors++; $display("FAIL drain_tready: got %0d stalled beats expected 0", nr); end
      checks++; if (wf_write_ready !== 1'b1 || slot_valid !== 4'b1110) begin errors++; $display("FAIL drain_state: got ready=%b slot_valid=%b expected 1, 1110", wf_write_ready, slot_valid); end
      run_replay(3, 8, 0, 1'b0, 0, -1, n, lp, nl, de, he, sp, to);
      checks++; if (to !== 0 || n !== 8 || lp !== 8 || de !== 0) begin errors++; $display("FAIL drain_replay: got %0d words, tlast at %0d, %0d bad expected 8, 8, 0", n, lp, de); end
   endtask

   task automatic test_bad_len;
      int e, nr;
      send_write(1, 0, 0, 0, e, nr);
      checks++; if (e !== 1) begin errors++; $display("FAIL len0_err: got %0d pulse cycles expected 1", e); end
      checks++; if (wf_write_ready !== 1'b1 || slot_valid !== 4'b1110) begin errors++; $display("FAIL len0_state: got ready=%b slot_valid=%b expected 1, 1110", wf_write_ready, slot_valid); end
      send_write(1, 1025, 0, 0, e, nr);
      checks++; if (e !== 1) begin errors++; $display("FAIL len_over_err: got %0d pulse cycles expected 1", e); end
      checks++; if (wf_write_ready !== 1'b1 || slot_valid !== 4'b1110) begin errors++; $display("FAIL len_over_state: got ready=%b slot_valid=%b expected 1, 1110", wf_write_ready, slot_valid); end
   endtask

   task automatic test_empty_slot;
      int seen, busy;
      seen = 0;
      busy = 0;
      params        = '0;
      params[39:36] = 4'd0;
      out_ready     = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_in1);
         if (out_valid) seen++;
         if (!wf_write_ready) busy++;
      end
      out_ready = 1'b0;
      checks++; if (seen !== 0) begin errors++; $display("FAIL empty_slot_valid: got %0d valid cycles expected 0", seen); end
      checks++; if (busy !== 0) begin errors++; $display("FAIL empty_slot_ready: got %0d not-ready cycles expected 0", busy); end
   endtask

   task automatic test_len_one;
      int e, nr, n, lp, nl, de, he, sp, to;
      send_write(0, 1, 1, 1, e, nr);
      checks++; if (e !== 0 || slot_valid !== 4'b1111) begin errors++; $display("FAIL len1_write: got err=%0d slot_valid=%b expected 0, 1111", e, slot_valid); end
      run_replay(0, 1, 0, 1'b0, 0, -1, n, lp, nl, de, he, sp, to);
      checks++; if (to !== 0 || n !== 1 || lp !== 1 || de !== 0) begin errors++; $display("FAIL len1_n0: got %0d words, tlast at %0d, %0d bad expected 1, 1, 0", n, lp, de); end
      run_replay(0, 1, 2, 1'b0, 0, -1, n, lp, nl, de, he, sp, to);
      checks++; if (to !== 0 || n !== 3 || lp !== 3 || nl !== 1 || sp !== 3) begin errors++; $display("FAIL len1_n2: got %0d words, tlast at %0d, %0d tlasts, span %0d expected 3, 3, 1, 3", n, lp, nl, sp); end
   endtask

   task automatic test_reset_mid_replay;
      int n, seen;
      n = 0;
      seen = 0;
      params        = '0;
      params[39:36] = 4'd1;
      params[55:40] = 16'd3;
      out_ready     = 1'b1;
      @(negedge clk_in1);
      for (int i = 0; i < 100 && n < 5; i++) begin
         if (out_valid && out_ready) n++;
         @(negedge clk_in1);
      end
      checks++; if (n !== 5) begin errors++; $display("FAIL midreset_prefix: got %0d words before reset expected 5", n); end
      aresetn = 1'b0;
      @(negedge clk_in1);
      checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL midreset_out: got valid=%b last=%b expected 0, 0", out_valid, out_last); end
      checks++; if (slot_valid !== 4'b0000) begin errors++; $display("FAIL midreset_slots: got %b expected 0000", slot_valid); end
      out_ready = 1'b0;
      aresetn   = 1'b1;
      @(negedge clk_in1);
      checks++; if (wf_write_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", wf_write_ready); end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_in1);
         if (out_valid) seen++;
      end
      out_ready = 1'b0;
      checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_replay_after: got %0d valid cycles expected 0", seen); end
   endtask

`ifdef WFSTREAM_CONT_LOOP_EN
   task automatic test_cont_loop;
      int e, nr, n, lp, nl, de, he, sp, to;
      send_write(1, 8, 8, 8, e, nr);
      run_replay(1, 8, 0, 1'b1, 0, 19, n, lp, nl, de, he, sp, to);
      checks++; if (to !== 0 || n !== 24 || lp !== 24 || nl !== 1) begin errors++; $display("FAIL cont_stop: got %0d words, tlast at %0d, %0d tlasts expected 24, 24, 1", n, lp, nl); end
      checks++; if (de !== 0) begin errors++; $display("FAIL cont_data: got %0d bad words expected 0", de); end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      params        = '0;
      init_wf_write = 1'b0;
      wf_stop       = 1'b0;
      in_data       = '0;
      in_valid      = 1'b0;
      in_last       = 1'b0;
      out_ready     = 1'b0;
      aresetn       = 1'b0;
      test_reset();
      test_write_basic();
      test_replay_single();
      test_back_to_back();
      test_backpressure();
      test_short_tlast();
      test_missing_tlast();
      test_bad_len();
      test_empty_slot();
      test_len_one();
      test_reset_mid_replay();
`ifdef WFSTREAM_CONT_LOOP_EN
      test_cont_loop();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
